// File: rtl/gpu_ram_arb.sv
// Two-requester arbiter and pipeline in front of the GPU local RAM.
// The GPU normally wins; a refused external host request takes priority after EXT_MAX_WAIT cycles.
module gpu_ram_arb #(
    parameter int EXT_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        resetl,
    input  logic        gpu_req,
    input  logic        gpu_we,
    input  logic [9:0]  gpu_addr,
    input  logic [31:0] gpu_wdata,
    output logic        gpu_ack,
    output logic        gpu_rvalid,
    output logic [31:0] gpu_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [9:0]  ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_ack,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic [9:0]  ram_addr,
    output logic        ramen,
    output logic        gpu_memw,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(EXT_MAX_WAIT);

    logic [3:0]  wait_cnt_r;
    logic        ext_ack_s;
    logic        gpu_ack_s;
    logic        any_ack_s;
    logic        win_we_s;
    logic        win_ext_s;
    logic [9:0]  win_addr_s;
    logic [31:0] win_wdata_s;
    logic        tag1_rd_r;
    logic        tag1_ext_r;
    logic        tag2_rd_r;
    logic        tag2_ext_r;

    // Acks are forced low during reset so nothing is accepted into a pipeline being cleared.
    assign ext_ack_s = resetl & ext_req & (~gpu_req | (wait_cnt_r == MAX_WAIT_C));
    assign gpu_ack_s = resetl & gpu_req & ~ext_ack_s;
    assign any_ack_s = ext_ack_s | gpu_ack_s;
    assign ext_ack   = ext_ack_s;
    assign gpu_ack   = gpu_ack_s;

    // Winner mux: selects the accepted requester's command fields.
    always_comb begin
        win_ext_s   = 1'b0;
        win_we_s    = gpu_we;
        win_addr_s  = gpu_addr;
        win_wdata_s = gpu_wdata;
        if (ext_ack_s) begin
            win_ext_s   = 1'b1;
            win_we_s    = ext_we;
            win_addr_s  = ext_addr;
            win_wdata_s = ext_wdata;
        end else begin
            win_ext_s   = 1'b0;
        end
    end

    // Starvation counter: counts refused external cycles, cleared on grant or withdrawal.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            wait_cnt_r <= 4'd0;
        end else if (ext_req && !ext_ack_s) begin
            if (wait_cnt_r != MAX_WAIT_C) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Stage 1: register RAM controls and the read tag for the access accepted this cycle.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            ramen      <= 1'b0;
            gpu_memw   <= 1'b0;
            ram_addr   <= 10'd0;
            ram_wdata  <= 32'd0;
            tag1_rd_r  <= 1'b0;
            tag1_ext_r <= 1'b0;
        end else if (any_ack_s) begin
            ramen      <= 1'b1;
            gpu_memw   <= win_we_s;
            ram_addr   <= win_addr_s;
            tag1_rd_r  <= ~win_we_s;
            tag1_ext_r <= win_ext_s;
            if (win_we_s) begin
                ram_wdata <= win_wdata_s;
            end else begin
                ram_wdata <= ram_wdata;
            end
        end else begin
            ramen      <= 1'b0;
            gpu_memw   <= 1'b0;
            tag1_rd_r  <= 1'b0;
        end
    end

    // Stage 2: the tag tracks the RAM access cycle, then read data is steered to its owner.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            tag2_rd_r  <= 1'b0;
            tag2_ext_r <= 1'b0;
            gpu_rvalid <= 1'b0;
            ext_rvalid <= 1'b0;
            gpu_rdata  <= 32'd0;
            ext_rdata  <= 32'd0;
        end else begin
            tag2_rd_r  <= tag1_rd_r;
            tag2_ext_r <= tag1_ext_r;
            gpu_rvalid <= tag2_rd_r & ~tag2_ext_r;
            ext_rvalid <= tag2_rd_r & tag2_ext_r;
            if (tag2_rd_r && !tag2_ext_r) begin
                gpu_rdata <= ram_rdata;
            end else begin
                gpu_rdata <= gpu_rdata;
            end
            if (tag2_rd_r && tag2_ext_r) begin
                ext_rdata <= ram_rdata;
            end else begin
                ext_rdata <= ext_rdata;
            end
        end
    end

endmodule

// File: tb/tb_gpu_ram_arb.sv
// Directed self-checking bench for gpu_ram_arb with a one-cycle-latency RAM model.
`timescale 1ns/1ps
module tb_gpu_ram_arb;

    logic        clk;
    logic        resetl;
    logic        gpu_req, gpu_we, ext_req, ext_we;
    logic [9:0]  gpu_addr, ext_addr;
    logic [31:0] gpu_wdata, ext_wdata;
    logic        gpu_ack, gpu_rvalid, ext_ack, ext_rvalid;
    logic [31:0] gpu_rdata, ext_rdata;
    logic [9:0]  ram_addr;
    logic        ramen, gpu_memw;
    logic [31:0] ram_wdata, ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int gpu_rv_n = 0;
    int ext_rv_n = 0;
    int a60_n    = 0;
    int g0, e0;

    logic        model_clr;
    logic [31:0] mem [1024];
    logic [1023:0] wr_v;

    gpu_ram_arb #(.EXT_MAX_WAIT(4)) dut (
        .clk(clk), .resetl(resetl),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
        .gpu_ack(gpu_ack), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ram_addr(ram_addr), .ramen(ramen), .gpu_memw(gpu_memw),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back an address-derived pattern.
    function automatic logic [31:0] ram_init(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    // RAM model: access in the ramen cycle, read data available the next cycle.
    always @(posedge clk) begin
        if (model_clr) begin
            wr_v <= '0;
        end else if (ramen) begin
            if (gpu_memw) begin
                mem[ram_addr]  <= ram_wdata;
                wr_v[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= wr_v[ram_addr] ? mem[ram_addr] : ram_init(ram_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (gpu_rvalid) gpu_rv_n <= gpu_rv_n + 1;
        if (ext_rvalid) ext_rv_n <= ext_rv_n + 1;
        if (ramen && ram_addr == 10'h060) a60_n <= a60_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes gpu_req is held and ext_req was just raised: grant must land on the 5th cycle.
    task automatic ext_wait_seq(input string tag, input logic [9:0] a);
        for (int i = 1; i <= 5; i++) begin
            #1;
            check_eq({tag, "_ext_ack"}, {31'd0, ext_ack}, {31'd0, i == 5});
            check_eq({tag, "_gpu_ack"}, {31'd0, gpu_ack}, {31'd0, i != 5});
            tick();
        end
        ext_req = 1'b0;
        check_eq({tag, "_ram_ctl"}, {ramen, gpu_memw, 20'd0, ram_addr}, {1'b1, 1'b0, 20'd0, a});
    endtask

    initial begin
        resetl = 1'b0; model_clr = 1'b1;
        gpu_req = 1'b1; ext_req = 1'b1; gpu_we = 1'b0; ext_we = 1'b0;
        gpu_addr = 10'd0; ext_addr = 10'd0; gpu_wdata = 32'd0; ext_wdata = 32'd0;

        // Reset with both requests high
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_ctl", {26'd0, ramen, gpu_memw, gpu_rvalid, ext_rvalid, gpu_ack, ext_ack}, 32'd0);
            check_eq("rst_data", {ram_addr, 22'd0} | ram_wdata | gpu_rdata | ext_rdata, 32'd0);
        end
        model_clr = 1'b0;
        resetl = 1'b1;
        #1;
        check_eq("rel_gpu_ack", {31'd0, gpu_ack}, 32'd1);
        check_eq("rel_ext_ack", {31'd0, ext_ack}, 32'd0);
        gpu_req = 1'b0; ext_req = 1'b0;
        tick(); tick(); tick(); tick();

        // GPU write then read of the same address
        g0 = gpu_rv_n; e0 = ext_rv_n;
        gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 10'h005; gpu_wdata = 32'hDEADBEEF;
        #1; check_eq("wr_ack", {31'd0, gpu_ack}, 32'd1);
        tick();
        check_eq("wr_ctl", {ramen, gpu_memw, 20'd0, ram_addr}, {2'b11, 20'd0, 10'h005});
        check_eq("wr_data", ram_wdata, 32'hDEADBEEF);
        gpu_we = 1'b0;
        #1; check_eq("rd_ack", {31'd0, gpu_ack}, 32'd1);
        tick();
        check_eq("rd_ctl", {ramen, gpu_memw, 20'd0, ram_addr}, {2'b10, 20'd0, 10'h005});
        gpu_req = 1'b0;
        tick();
        check_eq("rd_idle", {30'd0, ramen, gpu_rvalid}, 32'd0);
        tick();
        check_eq("rd_rvalid", {31'd0, gpu_rvalid}, 32'd1);
        check_eq("rd_rdata", gpu_rdata, 32'hDEADBEEF);
        tick();
        check_eq("rd_pulse", {31'd0, gpu_rvalid}, 32'd0);
        check_eq("rd_hold", gpu_rdata, 32'hDEADBEEF);
        check_eq("rd_gpu_cnt", gpu_rv_n - g0, 32'd1);
        check_eq("rd_ext_cnt", ext_rv_n - e0, 32'd0);

        // Bounded wait: GPU busy, external read of 0x3FF
        gpu_req = 1'b1; gpu_addr = 10'h100;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'h3FF;
        ext_wait_seq("bw", 10'h3FF);
        #1; check_eq("bw_gpu_back", {31'd0, gpu_ack}, 32'd1);
        tick();
        gpu_req = 1'b0;
        tick();
        check_eq("bw_ext_rvalid", {31'd0, ext_rvalid}, 32'd1);
        check_eq("bw_ext_rdata", ext_rdata, ram_init(10'h3FF));
        check_eq("bw_gpu_rvalid", {31'd0, gpu_rvalid}, 32'd0);
        tick(); tick(); tick(); tick();

        // Interleaved reads from both sources, no bubbles
        gpu_req = 1'b1; gpu_addr = 10'h010;
        #1; check_eq("il_ack0", {30'd0, gpu_ack, ext_ack}, 32'd2);
        tick();
        gpu_addr = 10'h011;
        #1; check_eq("il_ack1", {30'd0, gpu_ack, ext_ack}, 32'd2);
        tick();
        gpu_req = 1'b0; ext_req = 1'b1; ext_addr = 10'h020;
        #1; check_eq("il_ack2", {30'd0, gpu_ack, ext_ack}, 32'd1);
        tick();
        ext_req = 1'b0;
        check_eq("il_ramen", {ramen, 21'd0, ram_addr}, {1'b1, 21'd0, 10'h020});
        check_eq("il_rv0", {30'd0, gpu_rvalid, ext_rvalid}, 32'd2);
        check_eq("il_d0", gpu_rdata, ram_init(10'h010));
        tick();
        check_eq("il_rv1", {30'd0, gpu_rvalid, ext_rvalid}, 32'd2);
        check_eq("il_d1", gpu_rdata, ram_init(10'h011));
        tick();
        check_eq("il_rv2", {30'd0, gpu_rvalid, ext_rvalid}, 32'd1);
        check_eq("il_d2", ext_rdata, ram_init(10'h020));
        check_eq("il_gpu_keep", gpu_rdata, ram_init(10'h011));
        tick(); tick();

        // Reset one cycle after a GPU read ack
        gpu_req = 1'b1; gpu_addr = 10'h005;
        #1; check_eq("rr_ack", {31'd0, gpu_ack}, 32'd1);
        tick();
        gpu_req = 1'b0; resetl = 1'b0;
        tick();
        check_eq("rr_ctl", {30'd0, ramen, gpu_rvalid}, 32'd0);
        check_eq("rr_rdata", gpu_rdata, 32'd0);
        resetl = 1'b1;
        g0 = gpu_rv_n;
        tick(); tick(); tick(); tick();
        check_eq("rr_no_rvalid", gpu_rv_n - g0, 32'd0);

        // External pulse while GPU busy, then a full-length wait again
        gpu_req = 1'b1; gpu_addr = 10'h050;
        ext_req = 1'b1; ext_addr = 10'h060;
        #1; check_eq("ep_ack", {30'd0, gpu_ack, ext_ack}, 32'd2);
        tick();
        ext_req = 1'b0;
        tick();
        ext_req = 1'b1;
        ext_wait_seq("ep", 10'h060);
        gpu_req = 1'b0;
        tick(); tick(); tick(); tick();
        check_eq("ep_ram_hits", a60_n, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
